pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//   Consumer of the 2-bit NPCOp select: owns the program counter and sequences instruction fetch.
//   Issues fetch requests to instruction memory and waits for the datapath to resolve the current
//   instruction's NPCOp. It then computes and commits the next PC (PC+4 / branch / jump).
//   Sits between the instruction memory port and the decode/control stage of the multicycle CPU.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC value loaded on reset; first fetch address
// PORTS
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   npc_op        in   2   next-PC select, `NPC_PLUS4/`NPC_BRANCH/`NPC_JUMP encodings
//   npc_valid     in   1   npc_op and imm26 are resolved for the current instruction
//   imm26         in  26   instr[25:0]; [15:0] is the branch offset, all 26 bits form the jump index
//   rs_data       in  32   jump-register target (present only with NPC_JR_EN)
//   stall         in   1   datapath hold; blocks npc_valid consumption
//   imem_ready    in   1   instruction memory has data for imem_addr this cycle
//   imem_req      out  1   fetch request; imem_addr valid while high
//   imem_addr     out 32   equals pc
//   instr_latch   out  1   1-cycle pulse: datapath captures instruction word this cycle
//   pc            out 32   current PC
//   pc_plus4      out 32   pc + 4 (for link/branch use)
//   misalign_err  out  1   sticky JR misalignment flag (present only with NPC_JR_EN)
// BEHAVIOUR
//   Reset (async, any state): pc=RESET_PC, state=S_RST, imem_req=0, instr_latch=0, misalign_err=0.
//   Outputs are registered or decoded from state/pc only.
//   FSM:
//   - S_RST:   imem_req=0; unconditionally -> S_FETCH next cycle.
//   - S_FETCH: imem_req=1, imem_addr=pc. On imem_ready: instr_latch=1 for that cycle -> S_EXEC.
//              npc_valid is ignored in this state.
//   - S_EXEC:  imem_req=0. On npc_valid && !stall: pc <= next_pc -> S_FETCH.
//              npc_valid && stall: pc holds, op not consumed, stays S_EXEC.
//   Latency: accepted npc_valid -> imem_req high on new pc next cycle. Minimum loop is 2 cycles/instr.
//   next_pc arithmetic, modulo 2^32:
//   - `NPC_PLUS4:  pc + 4. 32'hFFFF_FFFC wraps to 32'h0000_0000.
//   - `NPC_BRANCH: pc_plus4 + {{14{imm26[15]}}, imm26[15:0], 2'b00}.
//   - `NPC_JUMP:   {pc_plus4[31:28], imm26, 2'b00}.
//   - 2'b11:       see CONFIGURATION.
//   pc[1:0] is always 2'b00.
//   Reset asserted mid-fetch aborts the request combinationally (imem_req drops with rst).
// CONFIGURATION
//   NPC_JR_EN defined:
//   - rs_data and misalign_err ports exist. 2'b11 = `NPC_JR: next_pc = {rs_data[31:2], 2'b00}.
//   - rs_data[1:0] != 0 sets misalign_err (sticky until rst).
//   NPC_JR_EN undefined:
//   - Ports absent. 2'b11 is treated as `NPC_PLUS4.
// STRUCTURE
//   - ctrl_encode_def.v holds the NPC_* encodings; `NPC_JR = 2'b11 is added there.
//   - State encodings are localparams of this module.
//   - One combinational sub-module, npc_calc (pc, npc_op, imm26[, rs_data] -> next_pc, misaligned).
//     The FSM and PC register stay in pc_fetch_ctrl.
// TESTING
//   1. rst=1 -> pc=32'h3000, imem_req=0. Release rst -> S_RST for 1 cycle, then imem_req=1,
//      imem_addr=32'h3000. Reassert rst while imem_req=1 -> imem_req=0 immediately.
//   2. imem_ready=1, then npc_valid with op=`NPC_PLUS4 -> pc=32'h3004, instr_latch pulsed once.
//      Force pc=32'hFFFF_FFFC with PLUS4 -> pc=32'h0.
//   3. At pc=32'h3004: BRANCH, imm16=16'hFFFF -> pc=32'h3004; BRANCH, imm16=16'h0002 -> pc=32'h3010.
//   4. JUMP, imm26=26'h0000C10 -> pc=32'h0000_3040.
//   5. npc_valid=1 with stall=1 for 3 cycles -> pc unchanged, imem_req=0.
//      Drop stall -> pc updates next edge. npc_valid asserted in S_FETCH -> ignored.
//   6. NPC_JR_EN: op=2'b11, rs_data=32'h0000_3102 -> pc=32'h3100, misalign_err=1 and held.
//      Without NPC_JR_EN: op=2'b11 -> pc+4.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC/fetch controller: next-PC select encodings and reset PC.
// The optional jump-register path is enabled with the NPC_JR_EN macro.
package pc_fetch_ctrl_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/pc_fetch_ctrl_npc_calc.sv
// Combinational next-PC arithmetic (PC+4 / branch / jump, plus jump-register when NPC_JR_EN is defined).
// All sums wrap modulo 2^32.
module npc_calc
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic [25:0] imm26,
`ifdef NPC_JR_EN
  input  logic [31:0] rs_data,
  output logic        misaligned,
`endif
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
`ifdef NPC_JR_EN
    misaligned = 1'b0;
`endif
    case (npc_op)
      NPC_BRANCH: next_pc = pc_plus4 + branch_off;
      NPC_JUMP:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
`ifdef NPC_JR_EN
      NPC_JR: begin
        next_pc    = {rs_data[31:2], 2'b00};
        misaligned = (rs_data[1:0] != 2'b00);
      end
`endif
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and fetch sequencer: S_RST -> S_FETCH -> S_EXEC -> S_FETCH ...
// Optional jump-register target and sticky misalignment flag with NPC_JR_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_op,
  input  logic        npc_valid,
  input  logic [25:0] imm26,
`ifdef NPC_JR_EN
  input  logic [31:0] rs_data,
  output logic        misalign_err,
`endif
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_latch,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_RST   = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  // Handshakes: a fetch completes in any S_FETCH cycle where imem_req && imem_ready;
  // an op is consumed in any S_EXEC cycle where npc_valid && !stall, otherwise it is held.
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        accept;
`ifdef NPC_JR_EN
  logic        misaligned;
  logic        err_q;
`endif

  npc_calc u_npc_calc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .imm26    (imm26),
`ifdef NPC_JR_EN
    .rs_data  (rs_data),
    .misaligned(misaligned),
`endif
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  assign accept = (state_q == S_EXEC) && npc_valid && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= {RESET_PC[31:2], 2'b00};
    end else begin
      state_q <= state_d;
      if (accept) pc_q <= next_pc;
    end
  end

`ifdef NPC_JR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      err_q <= 1'b0;
    else if (accept && misaligned) err_q <= 1'b1;
  end
  assign misalign_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (imem_ready) state_d = S_EXEC;
      S_EXEC:  if (accept)     state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  // imem_req is gated by rst so an in-flight request drops in the same cycle reset rises.
  always_comb begin
    imem_req    = (state_q == S_FETCH) && !rst;
    instr_latch = imem_req && imem_ready;
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign state_dbg = state_q;

endmodule
